// File: rtl/master_sequencer.sv
// Master phase counter and digit feeder for the online divider: NUM_DIGITS input
// iterations, DELTA zero-fill iterations, then a one-cycle done pulse.
// Optional build macro MASTER_SEQ_STALL_EN: in_valid gates the phase-0 digit slot.
module master_sequencer #(
    parameter int unsigned NUM_DIGITS = 32,
    parameter int unsigned DELTA      = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [1:0] x_digit,
    input  logic [1:0] d_digit,
    output logic [1:0] x_out,
    output logic [1:0] d_out,
    output logic [8:0] cnt_master,
    output logic       busy,
    output logic       done
);

    localparam int unsigned CNT_W    = 9;
    localparam int unsigned IDX_W    = 7;
    localparam int unsigned DIG_W    = 2;
    localparam int unsigned LAST_CNT = 4 * (NUM_DIGITS + DELTA) - 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        ZFILL = 2'd2
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] digit_idx;

    logic phase0_c;
    logic phase3_c;
    logic digits_left_c;
    logic last_cnt_c;
    logic take_c;
    logic finish_c;

    assign phase0_c      = (cnt_master[1:0] == 2'b00);
    assign phase3_c      = (cnt_master[1:0] == 2'b11);
    assign digits_left_c = (digit_idx < IDX_W'(NUM_DIGITS));
    assign last_cnt_c    = (cnt_master == CNT_W'(LAST_CNT));

    // Digit slot is open only at phase 0 of an input iteration.
    assign in_ready = (state == RUN) && phase0_c && digits_left_c;

`ifdef MASTER_SEQ_STALL_EN
    assign take_c = in_ready && in_valid;
`else
    logic unused_in_valid;
    assign unused_in_valid = in_valid;
    assign take_c          = in_ready;
`endif

    // RUN can only reach the final count directly when there is no zero fill.
    assign finish_c = last_cnt_c &&
                      ((state == ZFILL) || ((state == RUN) && !digits_left_c && phase3_c));

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            digit_idx  <= '0;
            cnt_master <= '0;
            x_out      <= '0;
            d_out      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (finish_c) begin
                state      <= IDLE;
                digit_idx  <= '0;
                cnt_master <= '0;
                x_out      <= '0;
                d_out      <= '0;
                busy       <= 1'b0;
                done       <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        digit_idx  <= '0;
                        cnt_master <= '0;
                        x_out      <= '0;
                        d_out      <= '0;
                        busy       <= 1'b0;
                        // A start landing on the done cycle belongs to the finished run.
                        if (start && !done) begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (take_c) begin
                            x_out      <= DIG_W'(x_digit);
                            d_out      <= DIG_W'(d_digit);
                            digit_idx  <= digit_idx + IDX_W'(1);
                            cnt_master <= cnt_master + CNT_W'(1);
                        end else if (!phase0_c) begin
                            cnt_master <= cnt_master + CNT_W'(1);
                            if (phase3_c && !digits_left_c) begin
                                state <= ZFILL;
                            end
                        end
                    end
                    ZFILL: begin
                        cnt_master <= cnt_master + CNT_W'(1);
                        if (phase0_c) begin
                            x_out <= '0;
                            d_out <= '0;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/master_sequencer.md
# master_sequencer

Generates the 9-bit master phase counter `cnt_master` for the online divider and feeds one radix-2 signed-digit pair per iteration to the datapath. It sits directly upstream of the computation control stage: that stage decodes `cnt_master[8:2]` as the iteration number and `cnt_master[1:0]` as the phase within the iteration. The sequencer runs NUM_DIGITS input iterations followed by DELTA zero-fill iterations covering the online delay, then pulses `done`.

## Interface
Parameters:
- NUM_DIGITS, 32, input digits per operand; 1..124.
- DELTA, 3, online delay in iterations; zero digits fed after the last input digit; NUM_DIGITS+DELTA ≤ 128.

Ports:
- clk  in  1  rising-edge clock; the block's only clock.
- rst  in  1  reset, synchronous and active-high.
- start  in  1  one-cycle request to begin a division; honoured only in IDLE.
- in_valid  in  1  source has a digit pair on x_digit/d_digit.
- in_ready  out  1  sequencer samples digits this cycle (combinational).
- x_digit  in  2  dividend digit {plus, minus}.
- d_digit  in  2  divisor digit {plus, minus}.
- x_out  out  2  registered dividend digit to the datapath.
- d_out  out  2  registered divisor digit to the datapath.
- cnt_master  out  9  master phase counter to computation control.
- busy  out  1  high in RUN and ZFILL.
- done  out  1  one-cycle pulse at completion.

## Operation
- States: IDLE, RUN, ZFILL.
- IDLE: cnt_master=0, busy=0, in_ready=0, x_out/d_out=0. start=1 → RUN on the next edge.
- Iteration k spans cnt_master = 4k..4k+3. The digit slot is phase 0, where cnt_master[1:0]==2'b00.
- RUN:
  - in_ready=1 at phase 0 only, while digit_idx < NUM_DIGITS.
  - Transfer = in_valid && in_ready. On a transfer, x_out/d_out ← inputs, digit_idx increments, and cnt_master increments.
  - At phase 0 with in_valid=0 the block stalls: cnt_master, x_out and d_out hold.
  - At phases 1..3, cnt_master increments unconditionally.
  - After the transfer of digit NUM_DIGITS-1, the state moves to ZFILL at the following phase-0 boundary.
- ZFILL:
  - in_ready=0. x_out/d_out ← 0 at each phase 0. cnt_master increments every cycle.
  - When cnt_master == 4·(NUM_DIGITS+DELTA)−1, the next edge sets done=1 for one cycle, state=IDLE, cnt_master=0 and digit_idx=0.
- start while busy is ignored. start coinciding with done is ignored; a new start is accepted from the next cycle onward.
- Widths: cnt_master wraps never (bounded by the parameter limits). digit_idx is 7 bits.

## Timing
- Reset values: cnt_master=0, x_out=0, d_out=0, busy=0, done=0, in_ready=0, state=IDLE, digit_idx=0.
- start at edge t → busy=1 and cnt_master=0 during cycle t+1; in_ready can assert in cycle t+1.
- Digit latency: a transfer in cycle c presents the digits on x_out/d_out from cycle c+1, while cnt_master=4k+1.
- Unstalled run length from start: 4·(NUM_DIGITS+DELTA) cycles of busy, then done.
- Each stall cycle extends the run by exactly one cycle.
- rst=1 mid-operation: all outputs take reset values at that edge; any in-flight digit is discarded; done does not pulse.
- in_ready is purely a function of state, cnt_master[1:0] and digit_idx; it does not depend on in_valid.

## Configuration
- MASTER_SEQ_STALL_EN defined: stall behaviour as specified (in_valid gates phase 0).
- Not defined: in_valid is ignored. Digits are sampled at every RUN phase 0 and the counter never stalls; the source must guarantee data. in_ready behaves identically in both builds.

## Test plan
- Reset, then start with NUM_DIGITS=4, DELTA=3 and in_valid held 1 → cnt_master counts 0..27; in_ready is high at cnt 0,4,8,12; done pulses one cycle after cnt=27; busy is high for 28 cycles.
- Digit feed x=2'b10,01,00,10 and d=2'b01 constant → x_out shows each value from cnt 1,5,9,13; x_out=0 and d_out=0 from cnt 17 onward.
- in_valid=0 for 3 cycles at cnt_master=8 (stall build) → cnt_master holds 8 for 3 cycles; done arrives 3 cycles late; digits are unchanged.
- Same stimulus without MASTER_SEQ_STALL_EN → no hold; digit sampled at cnt 8 regardless of in_valid.
- rst asserted at cnt_master=13 → next cycle cnt_master=0, busy=0, no done pulse; a subsequent start runs a full 28-cycle sequence.
- start pulsed at cnt_master=6 and again in the done cycle → both ignored; the block stays IDLE after done.
